// File: rtl/alu_exception_unit.sv
// ---------------------------------------------------------------------------
// alu_exception_unit
//   Consumer side of the ALU status interface. It samples the ALU status byte
//   when an instruction commits and keeps the architectural Z/N/C/V flags up
//   to date. It also detects divide-by-zero, misaligned-address and
//   multiply-overflow exceptions, and runs the request/acknowledge/return
//   handshake with the control unit.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   status_in    ALU status byte: [7] zero, [6] mul ovf, [5] carry,
//                [4] negative, [3] misaligned, [2] div-by-zero, [1:0] rsvd
//   status_valid instruction owning status_in commits this cycle
//   pc_in        PC of the committing instruction
//   exc_en       global exception enable
//   exc_ack      control unit accepts the pending exception
//   eret         handler finished, return from exception
//   exc_req      exception pending (held until acknowledged)
//   stall        pipeline hold while an exception is pending
//   in_handler   handler is running
//   cause        00 none, 01 div-by-zero, 10 misaligned, 11 mul overflow
//   pend_bits    every enabled exception bit seen at capture {ovf, mis, dz}
//   epc          PC of the faulting instruction
//   flags        architectural {Z, N, C, V}
//   double_fault sticky: exception detected while the handler was running
//   exc_count    saturating count of captured exceptions
// ---------------------------------------------------------------------------
module alu_exception_unit #(
    parameter logic [7:0]  EXC_MASK  = 8'b0100_1100,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           status_in,
    input  logic                 status_valid,
    input  logic [31:0]          pc_in,
    input  logic                 exc_en,
    input  logic                 exc_ack,
    input  logic                 eret,
    output logic                 exc_req,
    output logic                 stall,
    output logic                 in_handler,
    output logic [1:0]           cause,
    output logic [2:0]           pend_bits,
    output logic [31:0]          epc,
    output logic [3:0]           flags,
    output logic                 double_fault,
    output logic [CNT_WIDTH-1:0] exc_count
);

    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned PEND_W  = 3;
    localparam int unsigned FLAG_W  = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_DZ   = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_MIS  = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_OVF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t state;

    // Decode of the committing status byte.
    logic [7:0]         masked_c;
    logic               hit_c;
    logic               clean_c;
    logic [CAUSE_W-1:0] cause_c;
    logic [PEND_W-1:0]  pend_c;
    logic [FLAG_W-1:0]  flags_c;
    logic               cnt_full_c;

    always_comb begin
        masked_c = status_in & EXC_MASK;
        hit_c    = status_valid & exc_en & (|masked_c);
        // A committing instruction that does not fault may update the flags.
        clean_c  = status_valid & ~hit_c;
        pend_c   = {masked_c[6], masked_c[3], masked_c[2]};
        flags_c  = {status_in[7], status_in[4], status_in[5], status_in[6]};

        // Divide-by-zero wins over misaligned, which wins over overflow.
        cause_c = CAUSE_NONE;
        if (masked_c[2]) begin
            cause_c = CAUSE_DZ;
        end else if (masked_c[3]) begin
            cause_c = CAUSE_MIS;
        end else if (masked_c[6]) begin
            cause_c = CAUSE_OVF;
        end

        cnt_full_c = &exc_count;
    end

    // Handshake FSM; the state-decoded outputs are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            exc_req      <= 1'b0;
            stall        <= 1'b0;
            in_handler   <= 1'b0;
            cause        <= CAUSE_NONE;
            pend_bits    <= '0;
            epc          <= '0;
            flags        <= '0;
            double_fault <= 1'b0;
            exc_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_c) begin
                        state     <= PENDING;
                        exc_req   <= 1'b1;
                        stall     <= 1'b1;
                        cause     <= cause_c;
                        pend_bits <= pend_c;
                        epc       <= pc_in;
                        if (!cnt_full_c) begin
                            exc_count <= exc_count + CNT_WIDTH'(1);
                        end
                    end else if (clean_c) begin
                        flags <= flags_c;
                    end
                end

                // Pipeline is frozen: commits are neither captured nor
                // allowed to touch the flags.
                PENDING: begin
                    if (exc_ack) begin
                        state      <= SERVICE;
                        exc_req    <= 1'b0;
                        stall      <= 1'b0;
                        in_handler <= 1'b1;
                    end
                end

                SERVICE: begin
                    if (hit_c) begin
                        double_fault <= 1'b1;
                    end else if (clean_c) begin
                        flags <= flags_c;
                    end
                    if (eret) begin
                        state      <= IDLE;
                        in_handler <= 1'b0;
                        cause      <= CAUSE_NONE;
                        pend_bits  <= '0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    exc_req    <= 1'b0;
                    stall      <= 1'b0;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exception_unit.sv
module tb_alu_exception_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  status_in;
    logic        status_valid;
    logic [31:0] pc_in;
    logic        exc_en;
    logic        exc_ack;
    logic        eret;

    logic        exc_req, stall, in_handler, double_fault;
    logic [1:0]  cause;
    logic [2:0]  pend_bits;
    logic [31:0] epc;
    logic [3:0]  flags;
    logic [7:0]  exc_count;

    logic        s_exc_req, s_stall, s_in_handler, s_double_fault;
    logic [1:0]  s_cause;
    logic [2:0]  s_pend_bits;
    logic [31:0] s_epc;
    logic [3:0]  s_flags;
    logic [1:0]  s_exc_count;

    int total = 0;
    int bad   = 0;

    alu_exception_unit dut (
        .clk(clk), .rst(rst), .status_in(status_in), .status_valid(status_valid),
        .pc_in(pc_in), .exc_en(exc_en), .exc_ack(exc_ack), .eret(eret),
        .exc_req(exc_req), .stall(stall), .in_handler(in_handler), .cause(cause),
        .pend_bits(pend_bits), .epc(epc), .flags(flags),
        .double_fault(double_fault), .exc_count(exc_count)
    );

    alu_exception_unit #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .status_in(status_in), .status_valid(status_valid),
        .pc_in(pc_in), .exc_en(exc_en), .exc_ack(exc_ack), .eret(eret),
        .exc_req(s_exc_req), .stall(s_stall), .in_handler(s_in_handler),
        .cause(s_cause), .pend_bits(s_pend_bits), .epc(s_epc), .flags(s_flags),
        .double_fault(s_double_fault), .exc_count(s_exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [7:0]  st;
        logic [31:0] pc;
        logic        en;
        logic        ack;
        logic        er;
        logic        req;
        logic        stl;
        logic        ih;
        logic [1:0]  cause;
        logic [2:0]  pend;
        logic [31:0] epc;
        logic [3:0]  flags;
        logic        df;
        logic [7:0]  cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return 64'({exc_req, stall, in_handler, cause, pend_bits, epc, flags,
                    double_fault, exc_count});
    endfunction

    task automatic drive(input logic sv, input logic [7:0] st, input logic [31:0] pc,
                         input logic en, input logic ack, input logic er);
        status_valid = sv;
        status_in    = st;
        pc_in        = pc;
        exc_en       = en;
        exc_ack      = ack;
        eret         = er;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              sv  st     pc            en   ack  er  | req stl ih cause pend    epc           flags    df  cnt
        vecs[0]  = '{1'b1, 8'h80, 32'h0,       1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'b000,32'h0,      4'b1000,1'b0,8'd0};
        vecs[1]  = '{1'b1, 8'h30, 32'h0,       1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'b000,32'h0,      4'b0110,1'b0,8'd0};
        vecs[2]  = '{1'b1, 8'h04, 32'h40,      1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd1,3'b001,32'h40,     4'b0110,1'b0,8'd1};
        vecs[3]  = '{1'b1, 8'h44, 32'h99,      1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd1,3'b001,32'h40,     4'b0110,1'b0,8'd1};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,       1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,2'd1,3'b001,32'h40,     4'b0110,1'b0,8'd1};
        vecs[5]  = '{1'b0, 8'h00, 32'h0,       1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd1,3'b001,32'h40,     4'b0110,1'b0,8'd1};
        vecs[6]  = '{1'b0, 8'h00, 32'h0,       1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,2'd0,3'b000,32'h40,     4'b0110,1'b0,8'd1};
        vecs[7]  = '{1'b1, 8'h4C, 32'h80,      1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd1,3'b111,32'h80,     4'b0110,1'b0,8'd2};
        vecs[8]  = '{1'b0, 8'h00, 32'h0,       1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd1,3'b111,32'h80,     4'b0110,1'b0,8'd2};
        vecs[9]  = '{1'b0, 8'h00, 32'h0,       1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,2'd0,3'b000,32'h80,     4'b0110,1'b0,8'd2};
        vecs[10] = '{1'b1, 8'h48, 32'hC0,      1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd2,3'b110,32'hC0,     4'b0110,1'b0,8'd3};
        vecs[11] = '{1'b0, 8'h00, 32'h0,       1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd2,3'b110,32'hC0,     4'b0110,1'b0,8'd3};
        vecs[12] = '{1'b1, 8'h08, 32'h100,     1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,2'd2,3'b110,32'hC0,     4'b0110,1'b1,8'd3};
        vecs[13] = '{1'b1, 8'hA0, 32'h104,     1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,2'd2,3'b110,32'hC0,     4'b1010,1'b1,8'd3};
        vecs[14] = '{1'b1, 8'h04, 32'h200,     1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,2'd0,3'b000,32'hC0,     4'b1010,1'b1,8'd3};
        vecs[15] = '{1'b1, 8'h04, 32'h204,     1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'b000,32'hC0,     4'b0000,1'b1,8'd3};
        vecs[16] = '{1'b1, 8'hB3, 32'h208,     1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'b000,32'hC0,     4'b1110,1'b1,8'd3};
        vecs[17] = '{1'b0, 8'h04, 32'h20C,     1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'b000,32'hC0,     4'b1110,1'b1,8'd3};
        vecs[18] = '{1'b0, 8'h00, 32'h0,       1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,2'd0,3'b000,32'hC0,     4'b1110,1'b1,8'd3};
        vecs[19] = '{1'b1, 8'h40, 32'h300,     1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,2'd3,3'b100,32'h300,    4'b1110,1'b1,8'd4};
        vecs[20] = '{1'b1, 8'h80, 32'h0,       1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd3,3'b100,32'h300,    4'b1110,1'b1,8'd4};

        rst = 1'b1;
        drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack_out(), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sv, vecs[i].st, vecs[i].pc, vecs[i].en, vecs[i].ack, vecs[i].er);
            step();
            check($sformatf("vec%0d", i), pack_out(),
                  64'({vecs[i].req, vecs[i].stl, vecs[i].ih, vecs[i].cause, vecs[i].pend,
                       vecs[i].epc, vecs[i].flags, vecs[i].df, vecs[i].cnt}));
        end

        // Leave the handler, raise a fresh exception, then reset between edges.
        drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'h08, 32'h400, 1'b1, 1'b0, 1'b0);
        step();
        check("pre_reset_req", 64'({exc_req, stall, exc_count}), 64'({1'b1, 1'b1, 8'd5}));
        drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req", 64'({exc_req, stall, in_handler}), 64'h0);
        check("async_rst_cnt", 64'(exc_count), 64'h0);
        check("async_rst_epc", 64'(epc), 64'h0);
        check("async_rst_df_flags", 64'({double_fault, flags, cause, pend_bits}), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Four full exception round trips; the 2-bit counter must stick at 3.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'h04, 32'h500 + 32'(k), 1'b1, 1'b0, 1'b0);
            step();
            drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0);
            step();
            drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        check("sat_small_cnt", 64'(s_exc_count), 64'd3);
        check("sat_wide_cnt", 64'(exc_count), 64'd4);
        check("sat_epc_state", 64'({s_epc, s_exc_req, s_in_handler, s_double_fault}),
              64'({32'h503, 1'b0, 1'b0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exception_unit.md
Name: alu_exception_unit

Overview:
- Consumer side of the ALU status interface. Samples the 8-bit ALU status byte when the executing instruction commits.
- Maintains architectural condition flags (Z/N/C/V).
- Detects divide-by-zero, misaligned-address and multiply-overflow exceptions.
- Runs the request/acknowledge/return handshake with the control unit, capturing cause, EPC and a saturating exception count.

Parameters:
- EXC_MASK, 8'b0100_1100, status bits that may raise an exception (bit6 mul overflow, bit3 misaligned, bit2 div-by-zero).
- CNT_WIDTH, 8, width of the saturating exception counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- status_in  input  8  ALU status byte: [7] zero, [6] mul overflow, [5] carry, [4] negative, [3] misaligned, [2] div-by-zero, [1:0] reserved
- status_valid  input  1  instruction owning status_in commits this cycle
- pc_in  input  32  PC of committing instruction
- exc_en  input  1  global exception enable
- exc_ack  input  1  control unit accepts pending exception
- eret  input  1  handler finished, return from exception
- exc_req  output  1  exception pending, level held until ack
- stall  output  1  pipeline must hold (PENDING state)
- in_handler  output  1  SERVICE state
- cause  output  2  00 none, 01 div-by-zero, 10 misaligned, 11 mul overflow
- pend_bits  output  3  all enabled exception bits seen at capture {ovf, mis, dz}
- epc  output  32  PC of faulting instruction
- flags  output  4  {Z,N,C,V}
- double_fault  output  1  sticky: exception detected while in SERVICE
- exc_count  output  CNT_WIDTH  number of captured exceptions, saturating

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0. This includes flags, cause, pend_bits, epc, double_fault and exc_count. Reset mid-handshake aborts without a further event.
- hit = status_valid & exc_en & |(status_in & EXC_MASK). Bits [1:0] are ignored.
- Priority for cause: div-by-zero > misaligned > mul overflow.
- FSM states:
  - IDLE:
    - If hit: next cycle state=PENDING; cause, pend_bits and epc=pc_in are registered; exc_count+1 (saturates at all-ones).
    - If status_valid & !hit: flags <= {status_in[7], status_in[4], status_in[5], status_in[6]}.
    - exc_ack and eret are ignored.
  - PENDING:
    - exc_req=1, stall=1.
    - status_valid is ignored: no flag update and no new capture.
    - On exc_ack: next cycle state=SERVICE; exc_req and stall drop in that cycle.
    - eret is ignored.
  - SERVICE:
    - in_handler=1.
    - If status_valid & !hit: flags update as in IDLE.
    - If hit: double_fault <= 1; cause, epc and count are unchanged; flags are not updated.
    - On eret: next cycle state=IDLE; cause and pend_bits clear to 0; epc and double_fault are retained.
    - If eret and hit occur in the same cycle, double_fault is still set.
- Flag update on a faulting instruction: flags are NOT updated. Faulting results never become architectural.
- Latency: status_valid with a hit at edge N gives exc_req=1 after edge N. exc_ack sampled at edge M gives exc_req=0 after edge M.
- exc_en=0: no capture or count, but flags still update on every status_valid in IDLE/SERVICE.
- double_fault clears only on rst.
- All outputs are registered. There is no combinational path from inputs to outputs except stall/exc_req/in_handler, which are decoded from state.

Test Plan:
- Flag tracking: rst, then status_valid with status_in=8'h80 → flags=4'b1000; next status_in=8'h30 → flags=4'b0110; exc_req stays 0.
- Div-by-zero: status_in=8'h04, pc_in=32'h0000_0040, exc_en=1 → next cycle exc_req=1, stall=1, cause=01, pend_bits=3'b001, epc=32'h40, exc_count=1, flags unchanged. Then exc_ack → in_handler=1, exc_req=0. Then eret → IDLE, cause=00.
- Priority: status_in=8'h4C → cause=01, pend_bits=3'b111. Repeat with 8'h48 → cause=10, pend_bits=3'b110.
- Stall discipline: in PENDING, drive status_valid with 8'h44 → no change to cause, epc, count or flags. Drive eret alone → still PENDING.
- Double fault: in SERVICE, status_in=8'h08 → double_fault=1, epc and count unchanged. eret → IDLE with double_fault still 1. Mask/enable: exc_en=0 with 8'h04 → no exc_req, flags=4'b0000 written.
- Async reset: assert rst mid-PENDING, between clock edges → exc_req=0, exc_count=0 and epc=0 immediately. Saturation: with CNT_WIDTH=2, 4 full exception cycles → exc_count=3.
